// File: rtl/multicycle_control.sv
// Multicycle instruction controller: accepts one opcode per instruction via a
// valid/ready handshake and steps it through FETCH/DECODE/EXEC/MEM/WB, driving
// datapath strobes decoded from the state register and the latched opcode.
// The strobes have no combinational path from operation: they come from state
// and op_q, plus instr_valid for ir_write and mem_ready in MEM.
module multicycle_control #(
    parameter int unsigned OP_W        = 7,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TO_W        = 4,
    parameter int unsigned MEM_TIMEOUT = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  operation,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic             reg_branch,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic             reg_write,
    output logic [OP_W-1:0]  alu_op,
    output logic             illegal_op,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired
);

    localparam logic [OP_W-1:0] OP_JR   = OP_W'(7'b1000001);
    localparam logic [OP_W-1:0] OP_LD   = OP_W'(7'b0110000);
    localparam logic [OP_W-1:0] OP_ST   = OP_W'(7'b0110001);
    localparam logic [OP_W-1:0] OP_IMM0 = OP_W'(7'b0000100);
    localparam logic [OP_W-1:0] OP_IMM1 = OP_W'(7'b0000101);
    localparam logic [OP_W-1:0] OP_IMM2 = OP_W'(7'b0100000);
    localparam logic [OP_W-1:0] OP_IMM3 = OP_W'(7'b0100001);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [OP_W-1:0]  op_q;
    logic [TO_W-1:0]  to_cnt;
    logic             to_clr;
    logic             to_inc;
    logic             accept;
    logic             retire;
    logic [2:0]       top3;
    logic             is_br;
    logic             is_jr;
    logic             is_ld;
    logic             is_st;
    logic             is_imm;
    logic             is_ill;

    assign alu_op = op_q;

    // Opcode class decode from the latched opcode only
    always_comb begin
        top3   = op_q[OP_W-1 -: 3];
        is_br  = (top3 == 3'b100);
        is_jr  = (op_q == OP_JR);
        is_ld  = (op_q == OP_LD);
        is_st  = (op_q == OP_ST);
        is_imm = (op_q == OP_IMM0) || (op_q == OP_IMM1) ||
                 (op_q == OP_IMM2) || (op_q == OP_IMM3);
        is_ill = (top3 == 3'b101) || (top3 == 3'b110) || (top3 == 3'b111);
    end

    // State register, opcode latch, memory-wait timer and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op_q    <= '0;
            to_cnt  <= '0;
            retired <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_q <= operation;
            end
            if (to_clr) begin
                to_cnt <= '0;
            end else if (to_inc) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    // Next-state and per-state strobe decode
    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        reg_branch  = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src     = 1'b0;
        reg_write   = 1'b0;
        illegal_op  = 1'b0;
        mem_err     = 1'b0;
        accept      = 1'b0;
        retire      = 1'b0;
        to_clr      = 1'b0;
        to_inc      = 1'b0;

        case (state)
            S_IDLE: begin
                next_state = S_FETCH;
            end
            S_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept     = 1'b1;
                    ir_write   = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_ill) begin
                    illegal_op = 1'b1;
                    next_state = S_FETCH;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src = is_imm;
                if (is_br) begin
                    branch     = 1'b1;
                    reg_branch = is_jr;
                    pc_write   = 1'b1;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end else if (is_ld || is_st) begin
                    to_clr     = 1'b1;
                    next_state = S_MEM;
                end else begin
                    next_state = S_WB;
                end
            end
            S_MEM: begin
                mem_read  = is_ld;
                mem_write = is_st;
                // A response in the final allowed cycle still completes the access
                if (mem_ready) begin
                    if (is_ld) begin
                        next_state = S_WB;
                    end else begin
                        pc_write   = 1'b1;
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end
                end else if (to_cnt == TO_LAST) begin
                    mem_err    = 1'b1;
                    next_state = S_FETCH;
                end else begin
                    to_inc = 1'b1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_ld;
                pc_write   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one linear sequence of per-cycle
// vectors with hand-computed strobe patterns and retire counts.
module tb_multicycle_control;

    localparam int unsigned OP_W  = 7;
    localparam int unsigned CNT_W = 16;

    // Strobe bundle bit masks
    localparam logic [11:0] IRW  = 12'h800;
    localparam logic [11:0] PCW  = 12'h400;
    localparam logic [11:0] BRN  = 12'h200;
    localparam logic [11:0] RBR  = 12'h100;
    localparam logic [11:0] MRD  = 12'h080;
    localparam logic [11:0] MWR  = 12'h040;
    localparam logic [11:0] M2R  = 12'h020;
    localparam logic [11:0] ALUS = 12'h010;
    localparam logic [11:0] RWR  = 12'h008;
    localparam logic [11:0] ILL  = 12'h004;
    localparam logic [11:0] MERR = 12'h002;
    localparam logic [11:0] RDY  = 12'h001;
    localparam logic [11:0] NONE = 12'h000;

    logic             clk;
    logic             rst_n;
    logic [OP_W-1:0]  operation;
    logic             instr_valid;
    logic             instr_ready;
    logic             mem_ready;
    logic             ir_write;
    logic             pc_write;
    logic             branch;
    logic             reg_branch;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             alu_src;
    logic             reg_write;
    logic [OP_W-1:0]  alu_op;
    logic             illegal_op;
    logic             mem_err;
    logic [CNT_W-1:0] retired;
    logic [11:0]      strobes;

    int checks = 0;
    int errors = 0;

    multicycle_control #(
        .OP_W(OP_W),
        .CNT_W(CNT_W),
        .TO_W(4),
        .MEM_TIMEOUT(12)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .operation(operation),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .mem_ready(mem_ready),
        .ir_write(ir_write),
        .pc_write(pc_write),
        .branch(branch),
        .reg_branch(reg_branch),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_to_reg(mem_to_reg),
        .alu_src(alu_src),
        .reg_write(reg_write),
        .alu_op(alu_op),
        .illegal_op(illegal_op),
        .mem_err(mem_err),
        .retired(retired)
    );

    assign strobes = {ir_write, pc_write, branch, reg_branch, mem_read, mem_write,
                      mem_to_reg, alu_src, reg_write, illegal_op, mem_err, instr_ready};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs at the falling edge, then check the strobes
    task automatic cyc(input logic v, input logic [OP_W-1:0] op, input logic mr,
                       input logic [11:0] exp, input string tag);
        @(negedge clk);
        instr_valid = v;
        operation   = op;
        mem_ready   = mr;
        #1;
        chk(tag, 32'(strobes), 32'(exp));
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        operation   = '0;
        mem_ready   = 1'b0;

        // Reset and idle
        @(negedge clk);
        #1;
        chk("rst_strobes", 32'(strobes), 32'(NONE));
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_cycle1", 32'(strobes), 32'(NONE));
        for (int i = 0; i < 4; i++) cyc(1'b0, 7'b0000000, 1'b1, RDY, "idle_fetch");
        chk("idle_retired", 32'(retired), 32'd0);

        // IMM 0000100: stray valid in DECODE must not cause ir_write
        cyc(1'b1, 7'b0000100, 1'b0, IRW | RDY, "imm_accept");
        cyc(1'b1, 7'b1111111, 1'b0, NONE, "imm_decode");
        chk("imm_alu_op", 32'(alu_op), 32'h04);
        cyc(1'b0, 7'b0000000, 1'b1, ALUS, "imm_exec");
        cyc(1'b0, 7'b0000000, 1'b0, RWR | PCW, "imm_wb");
        chk("imm_ret_before", 32'(retired), 32'd0);
        cyc(1'b0, 7'b0000000, 1'b0, RDY, "imm_fetch");
        chk("imm_retired", 32'(retired), 32'd1);

        // JR 1000001
        cyc(1'b1, 7'b1000001, 1'b0, IRW | RDY, "jr_accept");
        cyc(1'b0, 7'b0000000, 1'b0, NONE, "jr_decode");
        cyc(1'b0, 7'b0000000, 1'b0, BRN | RBR | PCW, "jr_exec");
        cyc(1'b0, 7'b0000000, 1'b0, RDY, "jr_fetch");
        chk("jr_retired", 32'(retired), 32'd2);

        // Plain branch 1000000
        cyc(1'b1, 7'b1000000, 1'b0, IRW | RDY, "br_accept");
        cyc(1'b0, 7'b0000000, 1'b0, NONE, "br_decode");
        cyc(1'b0, 7'b0000000, 1'b0, BRN | PCW, "br_exec");
        cyc(1'b0, 7'b0000000, 1'b0, RDY, "br_fetch");
        chk("br_retired", 32'(retired), 32'd3);

        // Load, mem_ready in third MEM cycle
        cyc(1'b1, 7'b0110000, 1'b0, IRW | RDY, "ld_accept");
        cyc(1'b0, 7'b0000000, 1'b0, NONE, "ld_decode");
        cyc(1'b0, 7'b0000000, 1'b1, NONE, "ld_exec");
        cyc(1'b0, 7'b0000000, 1'b0, MRD, "ld_mem1");
        cyc(1'b0, 7'b0000000, 1'b0, MRD, "ld_mem2");
        cyc(1'b0, 7'b0000000, 1'b1, MRD, "ld_mem3");
        cyc(1'b0, 7'b0000000, 1'b0, RWR | M2R | PCW, "ld_wb");
        cyc(1'b0, 7'b0000000, 1'b0, RDY, "ld_fetch");
        chk("ld_retired", 32'(retired), 32'd4);

        // Store, mem_ready in third MEM cycle
        cyc(1'b1, 7'b0110001, 1'b0, IRW | RDY, "st_accept");
        cyc(1'b0, 7'b0000000, 1'b0, NONE, "st_decode");
        cyc(1'b0, 7'b0000000, 1'b0, NONE, "st_exec");
        cyc(1'b0, 7'b0000000, 1'b0, MWR, "st_mem1");
        cyc(1'b0, 7'b0000000, 1'b0, MWR, "st_mem2");
        cyc(1'b0, 7'b0000000, 1'b1, MWR | PCW, "st_mem3");
        cyc(1'b0, 7'b0000000, 1'b0, RDY, "st_fetch");
        chk("st_retired", 32'(retired), 32'd5);

        // Store timeout: mem_err in the 12th MEM cycle
        cyc(1'b1, 7'b0110001, 1'b0, IRW | RDY, "sto_accept");
        cyc(1'b0, 7'b0000000, 1'b0, NONE, "sto_decode");
        cyc(1'b0, 7'b0000000, 1'b0, NONE, "sto_exec");
        for (int i = 0; i < 11; i++) cyc(1'b0, 7'b0000000, 1'b0, MWR, "sto_wait");
        cyc(1'b0, 7'b0000000, 1'b0, MWR | MERR, "sto_timeout");
        cyc(1'b0, 7'b0000000, 1'b0, RDY, "sto_fetch");
        chk("sto_retired", 32'(retired), 32'd5);

        // Store with mem_ready exactly in the 12th cycle: ready wins
        cyc(1'b1, 7'b0110001, 1'b0, IRW | RDY, "stl_accept");
        cyc(1'b0, 7'b0000000, 1'b0, NONE, "stl_decode");
        cyc(1'b0, 7'b0000000, 1'b0, NONE, "stl_exec");
        for (int i = 0; i < 11; i++) cyc(1'b0, 7'b0000000, 1'b0, MWR, "stl_wait");
        cyc(1'b0, 7'b0000000, 1'b1, MWR | PCW, "stl_last");
        cyc(1'b0, 7'b0000000, 1'b0, RDY, "stl_fetch");
        chk("stl_retired", 32'(retired), 32'd6);

        // Illegal opcode 1110000
        cyc(1'b1, 7'b1110000, 1'b0, IRW | RDY, "ill_accept");
        cyc(1'b0, 7'b0000000, 1'b0, ILL, "ill_decode");
        cyc(1'b0, 7'b0000000, 1'b0, RDY, "ill_fetch");
        chk("ill_retired", 32'(retired), 32'd6);

        // Reset asserted during MEM of a load abandons it
        cyc(1'b1, 7'b0110000, 1'b0, IRW | RDY, "ldr_accept");
        cyc(1'b0, 7'b0000000, 1'b0, NONE, "ldr_decode");
        cyc(1'b0, 7'b0000000, 1'b0, NONE, "ldr_exec");
        cyc(1'b0, 7'b0000000, 1'b0, MRD, "ldr_mem1");
        @(negedge clk);
        mem_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk("ldr_rst_strobes", 32'(strobes), 32'(NONE));
        chk("ldr_rst_retired", 32'(retired), 32'd0);
        chk("ldr_rst_alu_op", 32'(alu_op), 32'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n     = 1'b1;
        #1;
        chk("ldr_idle", 32'(strobes), 32'(NONE));
        cyc(1'b0, 7'b0000000, 1'b0, RDY, "ldr_fetch");
        chk("ldr_retired", 32'(retired), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
